// File: rtl/mux_nto1_reg_pkg.sv
// Shared constants and helpers for the registered N-to-1 multiplexer.
package mux_nto1_reg_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   // Width needed to index n channels (at least 1).
   function automatic int clog2_f(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/mux_nto1_reg_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting channel after ptr, wrapping at NCH.
module rr_arbiter
   import mux_nto1_reg_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  gnt,
   output logic [SELW-1:0] gnt_idx,
   output logic            any
);

   int c;

   // Scan from lowest to highest priority so the nearest requester after ptr wins.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      c       = 0;
      for (int k = NCH; k >= 1; k--) begin
         c = int'(ptr) + k;
         if (c >= NCH) c = c - NCH;
         if (c < NCH && req[c]) begin
            gnt_idx = SELW'(c);
            any     = 1'b1;
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NCH; i++) begin
         if (any && int'(gnt_idx) == i) gnt[i] = 1'b1;
      end
   end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with per-channel valid/ready, external-select or round-robin.
module mux_nto1_reg
   import mux_nto1_reg_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int NCH    = 4,
   parameter int SELW   = 2,
   parameter int MODE   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DWIDTH-1:0] in_data,
   input  logic [NCH-1:0]        in_valid,
   output logic [NCH-1:0]        in_ready,
   input  logic [SELW-1:0]       sel,
   output logic [DWIDTH-1:0]     out_data,
   output logic                  out_valid,
   output logic [SELW-1:0]       out_chan,
   input  logic                  out_ready
);

   if (NCH < 2 || SELW < clog2_f(NCH)) begin : g_bad_params
      $error("mux_nto1_reg: need NCH >= 2 and SELW >= clog2(NCH)");
   end

   logic [SELW-1:0]   rr_ptr;
   logic [NCH-1:0]    grant;
   logic [SELW-1:0]   grant_idx;
   logic              grant_any;
   logic              load_ok;
   logic              accept;
   logic [DWIDTH-1:0] grant_data;

   if (MODE == MUX_MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;

      rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
         .req     (in_valid),
         .ptr     (rr_ptr),
         .gnt     (grant),
         .gnt_idx (grant_idx),
         .any     (grant_any)
      );
   end else begin : g_sel
      logic unused_ptr;
      assign unused_ptr = ^rr_ptr;

      // Out-of-range selects simply never match a channel, so no grant is issued.
      always_comb begin
         grant     = '0;
         grant_idx = sel;
         grant_any = 1'b0;
         for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_any = 1'b1;
            end
         end
      end
   end

   // Handshake: a word moves on an edge where valid and ready are both high on that side.
   // The output register can take a new word when empty or when its current word is
   // leaving in the same cycle, which is what keeps one word per cycle with no bubble.
   assign load_ok  = ~out_valid | out_ready;
   assign in_ready = load_ok ? grant : '0;
   assign accept   = load_ok & grant_any;

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NCH; i++) begin
         if (grant[i]) grant_data = in_data[i*DWIDTH +: DWIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         rr_ptr    <= SELW'(NCH - 1);
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_chan  <= grant_idx;
            rr_ptr    <= grant_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: RR (NCH=4), SEL (NCH=4) and SEL (NCH=3) instances, one active at a time.
module tb_mux_nto1_reg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   in_valid  [3];
   logic [1:0]   sel_s     [3];
   logic         out_ready [3];
   logic [127:0] in_data   [3];

   logic [3:0]  rdy0, rdy1;
   logic [2:0]  rdy2;
   logic [31:0] od0, od1, od2;
   logic        ov0, ov1, ov2;
   logic [1:0]  oc0, oc1, oc2;

   mux_nto1_reg #(.DWIDTH(32), .NCH(4), .SELW(2), .MODE(1)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(rdy0),
      .sel(sel_s[0]), .out_data(od0), .out_valid(ov0), .out_chan(oc0), .out_ready(out_ready[0]));

   mux_nto1_reg #(.DWIDTH(32), .NCH(4), .SELW(2), .MODE(0)) u_sel (
      .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(rdy1),
      .sel(sel_s[1]), .out_data(od1), .out_valid(ov1), .out_chan(oc1), .out_ready(out_ready[1]));

   mux_nto1_reg #(.DWIDTH(32), .NCH(3), .SELW(2), .MODE(0)) u_sel3 (
      .clk(clk), .rst(rst), .in_data(in_data[2][95:0]), .in_valid(in_valid[2][2:0]), .in_ready(rdy2),
      .sel(sel_s[2]), .out_data(od2), .out_valid(ov2), .out_chan(oc2), .out_ready(out_ready[2]));

   int act = 0;
   logic [3:0]  cur_rdy;
   logic [31:0] cur_od;
   logic        cur_ov;
   logic [1:0]  cur_oc;

   always_comb begin
      cur_rdy = rdy0; cur_od = od0; cur_ov = ov0; cur_oc = oc0;
      if (act == 1) begin
         cur_rdy = rdy1; cur_od = od1; cur_ov = ov1; cur_oc = oc1;
      end else if (act == 2) begin
         cur_rdy = {1'b0, rdy2}; cur_od = od2; cur_ov = ov2; cur_oc = oc2;
      end
   end

   int total = 0;
   int bad   = 0;
   logic [33:0] exp_q[$];
   logic mv = 1'b0;
   int   ptr = 3;

   function automatic int nch_of(input int a);
      return (a == 2) ? 3 : 4;
   endfunction

   // Reference grant: SEL picks sel if in range and valid; RR takes first valid after ptr.
   function automatic int model_grant(input int a, input logic [3:0] v, input int s, input int p);
      int n;
      n = nch_of(a);
      if (a != 0) return (s < n && v[s]) ? s : -1;
      for (int k = 1; k <= n; k++) begin
         if (v[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   task automatic do_reset(input bit chk_clear);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = '0; out_ready[i] = 1'b1; sel_s[i] = '0; in_data[i] = '0;
      end
      rst = 1'b1;
      mv  = 1'b0;
      exp_q.delete();
      #1;
      if (chk_clear) begin
         chk("rst_out_valid", 64'(cur_ov), 64'd0);
         chk("rst_out_data", 64'(cur_od), 64'd0);
         chk("rst_out_chan", 64'(cur_oc), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ptr = nch_of(act) - 1;
   endtask

   // Drive one cycle, check in_ready against the model and queue any accepted word.
   task automatic cycle(input logic [3:0] v, input int s, input logic r, input logic [127:0] d);
      int g;
      logic [3:0] exp_rdy;
      logic lok;
      @(negedge clk);
      in_valid[act] = v; sel_s[act] = 2'(s); out_ready[act] = r; in_data[act] = d;
      #1;
      g   = model_grant(act, v, s, ptr);
      lok = !mv || r;
      exp_rdy = (lok && g >= 0) ? 4'(1 << g) : 4'b0;
      chk("in_ready", 64'(cur_rdy), 64'(exp_rdy));
      if (exp_rdy != 0) exp_q.push_back({2'(g), d[g*32 +: 32]});
      @(posedge clk);
      if (exp_rdy != 0) begin
         mv  = 1'b1;
         ptr = g;
      end else if (r) begin
         mv = 1'b0;
      end
      #1;
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
               {$urandom, $urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 3; i++) cycle(4'b0, 0, 1'b1, '0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: compares out_valid each cycle and pops the scoreboard on every output transfer.
   always @(negedge clk) begin
      logic [33:0] e;
      #2;
      if (!rst) begin
         chk("out_valid", 64'(cur_ov), 64'(mv));
         if (cur_ov && out_ready[act]) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL out_word: got %0h with nothing expected", {cur_oc, cur_od});
            end else begin
               e = exp_q.pop_front();
               chk("out_word", 64'({cur_oc, cur_od}), 64'(e));
            end
         end
      end
   end

   logic [127:0] dd;

   initial begin
      for (int i = 0; i < 3; i++) begin
         in_valid[i] = '0; out_ready[i] = 1'b1; sel_s[i] = '0; in_data[i] = '0;
      end

      // RR instance
      act = 0;
      do_reset(1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(4'b1111, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
         chk("rr_seq_chan", 64'(cur_oc), 64'(k % 4));
      end
      cycle(4'b0100, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("rr_to_ch2", 64'(cur_oc), 64'd2);
      cycle(4'b0011, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("rr_wrap_ch0", 64'(cur_oc), 64'd0);
      cycle(4'b0011, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("rr_then_ch1", 64'(cur_oc), 64'd1);
      cycle(4'b1001, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("rr_skip_ch3", 64'(cur_oc), 64'd3);
      cycle(4'b1001, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("rr_wrap2_ch0", 64'(cur_oc), 64'd0);
      cycle(4'b1111, 0, 1'b0, {$urandom, $urandom, $urandom, $urandom});
      chk("pre_rst_valid", 64'(cur_ov), 64'd1);
      do_reset(1'b1);
      cycle(4'b1111, 0, 1'b1, {$urandom, $urandom, $urandom, $urandom});
      chk("post_rst_ch0", 64'(cur_oc), 64'd0);
      rand_run(300);

      // SEL instance, NCH=4
      act = 1;
      do_reset(1'b1);
      dd = '0;
      dd[95:64] = 32'hDEADBEEF;
      cycle(4'b0100, 2, 1'b1, dd);
      chk("sel_data", 64'(cur_od), 64'hDEADBEEF);
      chk("sel_chan", 64'(cur_oc), 64'd2);
      for (int k = 0; k < 5; k++) begin
         cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'b0,
               {$urandom, $urandom, $urandom, $urandom});
         chk("stall_data", 64'(cur_od), 64'hDEADBEEF);
      end
      dd = '0;
      dd[63:32] = 32'h12345678;
      cycle(4'b0010, 1, 1'b1, dd);
      chk("release_data", 64'(cur_od), 64'h12345678);
      chk("release_valid", 64'(cur_ov), 64'd1);
      cycle(4'b0000, 1, 1'b1, '0);
      chk("drain_valid", 64'(cur_ov), 64'd0);
      chk("drain_keeps_data", 64'(cur_od), 64'h12345678);
      chk("drain_keeps_chan", 64'(cur_oc), 64'd1);
      rand_run(300);

      // SEL instance, NCH=3 with out-of-range select
      act = 2;
      do_reset(1'b1);
      for (int k = 0; k < 4; k++) begin
         cycle(4'b0111, 3, 1'b1, {$urandom, $urandom, $urandom, $urandom});
         chk("sel_oor_valid", 64'(cur_ov), 64'd0);
      end
      rand_run(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
